id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Parametrised decode stage: integrated register file, full RV32 immediate generation, registered ID/EX output with valid/ready handshake.
- Adds load-use hazard stall, flush, and in-place operand refresh of a held instruction.
- Sits between the IF/ID register and the execute stage; the writeback stage drives the write port.

Parameters:
- XLEN, 32, datapath and register width.
- NUM_REGS, 32, architectural registers (16 for RV32E); indices >= NUM_REGS read 0 and ignore writes.
- AW, 5, register index width (fixed at 5 for encoding; NUM_REGS <= 32).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  decode input valid.
- in_ready  out  1  stage accepts in_instr this cycle.
- in_instr  in  32  instruction.
- in_pc  in  XLEN  instruction PC.
- flush  in  1  kill the held output and the incoming instruction.
- wb_we  in  1  writeback enable.
- wb_rd  in  AW  writeback index.
- wb_data  in  XLEN  writeback data.
- ex_is_load  in  1  instruction currently in EX is a valid load.
- ex_rd  in  AW  destination of the EX instruction.
- out_valid  out  1  ID/EX payload valid.
- out_ready  in  1  EX accepts payload.
- out_pc  out  XLEN  registered PC.
- out_rs1_data, out_rs2_data  out  XLEN  operands.
- out_imm  out  XLEN  sign-extended immediate.
- out_rs1, out_rs2, out_rd  out  AW  register indices.
- out_opcode  out  7  opcode.
- out_funct3  out  3  funct3.
- out_funct7  out  7  funct7.
- hazard_stall  out  1  load-use stall active (combinational).

Behaviour:
- Reset (reset=0, async): all registers cleared, including the register file and the output register; out_valid=0. All out_* data = 0.
- Register file: x0 reads 0 and x0 writes are ignored. Writes commit on the clk edge when wb_we=1. Reads are combinational on in_instr[19:15] / [24:20].
- Immediates, sign-extended to XLEN:
  - I: opcodes 0000011, 0010011, 1100111.
  - S: 0100011.
  - B: 1100011, bit0=0.
  - U: 0110111, 0010111, low 12 bits = 0.
  - J: 1101111, bit0=0.
  - Any other opcode: 0.
- Source usage:
  - uses_rs1 false for LUI, AUIPC, JAL.
  - uses_rs2 true only for S, B, R (0110011).
- hazard_stall = in_valid & ex_is_load & ex_rd!=0 & ((uses_rs1 & ex_rd==rs1) | (uses_rs2 & ex_rd==rs2)).
- in_ready = (!out_valid | out_ready) & !hazard_stall & !flush.
- Output register update, in priority order:
  1. flush: out_valid<=0 next edge; input not accepted.
  2. in_valid & in_ready: capture the decoded payload; out_valid<=1. Latency 1 cycle.
  3. out_ready & !in_accept: out_valid<=0. If hazard_stall is the cause, this inserts the bubble.
  4. Otherwise hold.
- Held refresh: while out_valid & !out_ready, a write with wb_we & wb_rd!=0 & wb_rd==out_rs1 updates out_rs1_data <= wb_data. Same rule for rs2. This prevents stale operands under backpressure.
- Payload fields are don't-care when out_valid=0, but must not change while out_valid=1 & !out_ready, except through held refresh.
- Reset mid-operation drops the in-flight payload; there is no replay.

Optional Feature:
- REGFILE_BYPASS_EN defined: a same-cycle write (wb_we, wb_rd==rs, rs!=0) bypasses to the read port, so the captured operand equals wb_data.
- Undefined: the read returns the old value, and the pipeline must tolerate a 1-cycle write-to-read gap.

Decomposition:
- Package id_pkg holds:
  - opcode constants (OP_LOAD, OP_IMM, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_REG).
  - imm_type_e enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
  - default XLEN.
- One sub-module, id_regfile: parametrised by XLEN/NUM_REGS, 2 read ports, 1 write port, optional bypass. Immediate decode stays inline.

Test Plan:
- Reset, then write x5=0x0000_00AA; then addi x6,x5,-1 (0xFFF28313) -> next cycle out_valid=1, out_rs1_data=0xAA, out_imm=0xFFFF_FFFF, out_rd=6.
- ex_is_load=1, ex_rd=5, in_instr uses rs1=x5 -> hazard_stall=1, in_ready=0, a bubble is issued. With ex_is_load=0 the next cycle, the instruction is accepted.
- out_ready=0 for 3 cycles with out_rs2=7, and wb writes x7=0x1234 during the hold -> out_rs2_data=0x1234 when released; the other fields are unchanged.
- flush=1 with in_valid=1 and out_valid=1 -> out_valid=0 next cycle and in_ready=0 during flush.
- Writes to x0 and, with NUM_REGS=16, to x20 -> subsequent reads return 0.
- Same-cycle wb x3=0x55 with read of x3: out_rs1_data=0x55 with REGFILE_BYPASS_EN, old value without it.

Source files
------------

// File: rtl/id_pkg.sv
// Shared decode constants for the ID stage: RV32 base opcodes, immediate formats, default width.
package id_pkg;

  localparam int XLEN_DEF = 32;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE
  } imm_type_e;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: imm_type = IMM_I;
      OP_STORE:                 imm_type = IMM_S;
      OP_BRANCH:                imm_type = IMM_B;
      OP_LUI, OP_AUIPC:         imm_type = IMM_U;
      OP_JAL:                   imm_type = IMM_J;
      default:                  imm_type = IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/id_regfile.sv
// 2R1W architectural register file; x0 and indices >= NUM_REGS read zero.
// Same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module id_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_we,
  input  logic [4:0]      i_wa,
  input  logic [XLEN-1:0] i_wd,
  input  logic [4:0]      i_ra1,
  input  logic [4:0]      i_ra2,
  output logic [XLEN-1:0] o_rd1,
  output logic [XLEN-1:0] o_rd2
);

  logic [XLEN-1:0] w_rf [32];

  // Only implemented, non-zero indices get storage; the rest are tied to zero.
  for (genvar g = 0; g < 32; g++) begin : g_ent
    if (g != 0 && g < NUM_REGS) begin : g_reg
      logic [XLEN-1:0] r_q;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         r_q <= '0;
        else if (i_we && i_wa == 5'(g))     r_q <= i_wd;
      end
      assign w_rf[g] = r_q;
    end else begin : g_zero
      assign w_rf[g] = '0;
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic w_byp1, w_byp2;
  assign w_byp1 = i_we && (i_wa == i_ra1) && (i_ra1 != '0) && ({1'b0, i_ra1} < 6'(NUM_REGS));
  assign w_byp2 = i_we && (i_wa == i_ra2) && (i_ra2 != '0) && ({1'b0, i_ra2} < 6'(NUM_REGS));
  assign o_rd1  = w_byp1 ? i_wd : w_rf[i_ra1];
  assign o_rd2  = w_byp2 ? i_wd : w_rf[i_ra2];
`else
  assign o_rd1 = w_rf[i_ra1];
  assign o_rd2 = w_rf[i_ra2];
`endif

endmodule

// File: rtl/id_stage_pipe.sv
// RV32 decode stage: regfile read, immediate generation, load-use stall, flush and a
// registered ID/EX payload with valid/ready. Optional REGFILE_BYPASS_EN forwards same-cycle writes.
module id_stage_pipe
  import id_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = 32,
  parameter int AW       = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            ex_is_load,
  input  logic [AW-1:0]   ex_rd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_rs1_data,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_imm,
  output logic [AW-1:0]   out_rs1,
  output logic [AW-1:0]   out_rs2,
  output logic [AW-1:0]   out_rd,
  output logic [6:0]      out_opcode,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic            hazard_stall
);

  logic [6:0]      w_op;
  logic [AW-1:0]   w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_rs1_data, w_rs2_data, w_imm;
  logic [31:0]     w_imm32;
  imm_type_e       w_itype;
  logic            w_uses_rs1, w_uses_rs2, w_accept;
  logic            w_wb_live, w_ref1, w_ref2;

  assign w_op  = in_instr[6:0];
  assign w_rd  = in_instr[11:7];
  assign w_rs1 = in_instr[19:15];
  assign w_rs2 = in_instr[24:20];

  id_regfile #(.XLEN(XLEN), .NUM_REGS(NUM_REGS)) u_rf (
    .clk   (clk),
    .reset (reset),
    .i_we  (wb_we),
    .i_wa  (wb_rd),
    .i_wd  (wb_data),
    .i_ra1 (w_rs1),
    .i_ra2 (w_rs2),
    .o_rd1 (w_rs1_data),
    .o_rd2 (w_rs2_data)
  );

  assign w_itype = imm_type(w_op);

  always_comb begin
    w_imm32 = '0;
    case (w_itype)
      IMM_I:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                          in_instr[30:25], in_instr[11:8], 1'b0};
      IMM_U:   w_imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                          in_instr[20], in_instr[30:21], 1'b0};
      default: w_imm32 = '0;
    endcase
  end
  assign w_imm = XLEN'($signed(w_imm32));

  assign w_uses_rs1 = !(w_op == OP_LUI || w_op == OP_AUIPC || w_op == OP_JAL);
  assign w_uses_rs2 = (w_op == OP_STORE || w_op == OP_BRANCH || w_op == OP_REG);

  assign hazard_stall = in_valid && ex_is_load && (ex_rd != '0) &&
                        ((w_uses_rs1 && ex_rd == w_rs1) || (w_uses_rs2 && ex_rd == w_rs2));
  assign in_ready = (!out_valid || out_ready) && !hazard_stall && !flush;
  assign w_accept = in_valid && in_ready;

  // A writeback that actually commits; used to keep held operands current under backpressure.
  assign w_wb_live = wb_we && (wb_rd != '0) && ({1'b0, wb_rd} < (AW+1)'(NUM_REGS));
  assign w_ref1    = w_wb_live && (wb_rd == out_rs1);
  assign w_ref2    = w_wb_live && (wb_rd == out_rs2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid    <= 1'b0;
      out_pc       <= '0;
      out_rs1_data <= '0;
      out_rs2_data <= '0;
      out_imm      <= '0;
      out_rs1      <= '0;
      out_rs2      <= '0;
      out_rd       <= '0;
      out_opcode   <= '0;
      out_funct3   <= '0;
      out_funct7   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept) begin
      out_valid    <= 1'b1;
      out_pc       <= in_pc;
      out_rs1_data <= w_rs1_data;
      out_rs2_data <= w_rs2_data;
      out_imm      <= w_imm;
      out_rs1      <= w_rs1;
      out_rs2      <= w_rs2;
      out_rd       <= w_rd;
      out_opcode   <= w_op;
      out_funct3   <= in_instr[14:12];
      out_funct7   <= in_instr[31:25];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end else if (out_valid) begin
      if (w_ref1) out_rs1_data <= wb_data;
      if (w_ref2) out_rs2_data <= wb_data;
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// Directed bench for id_stage_pipe (NUM_REGS=16 so out-of-range indices are exercised).
module tb_id_stage_pipe;

  localparam int XLEN = 32;
  localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid, in_ready, flush, wb_we, ex_is_load;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc, wb_data;
  logic [AW-1:0]   wb_rd, ex_rd;
  logic            out_valid, out_ready, hazard_stall;
  logic [XLEN-1:0] out_pc, out_rs1_data, out_rs2_data, out_imm;
  logic [AW-1:0]   out_rs1, out_rs2, out_rd;
  logic [6:0]      out_opcode, out_funct7;
  logic [2:0]      out_funct3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage_pipe #(.XLEN(XLEN), .NUM_REGS(16), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1_data(out_rs1_data), .out_rs2_data(out_rs2_data), .out_imm(out_imm),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
    .hazard_stall(hazard_stall)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wb_write(input logic [AW-1:0] rd, input logic [31:0] d);
    wb_we = 1'b1; wb_rd = rd; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0;
    wb_we = 0; wb_rd = '0; wb_data = '0; ex_is_load = 0; ex_rd = '0; out_ready = 1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", out_valid); end
    checks++; if (out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h exp 0", out_pc); end
    checks++; if (out_imm !== 32'h0 || out_rs1_data !== 32'h0) begin errors++; $display("FAIL reset_data got imm %h rs1 %h exp 0", out_imm, out_rs1_data); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    wb_write(5'd5, 32'h0000_00AA);
    wb_write(5'd1, 32'h11);
    wb_write(5'd2, 32'h22);
    in_valid = 1; in_instr = 32'hFFF2_8313; in_pc = 32'h100;
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b exp 1", out_valid); end
    checks++; if (out_rs1_data !== 32'hAA) begin errors++; $display("FAIL basic_rs1_data got %h exp 000000aa", out_rs1_data); end
    checks++; if (out_imm !== 32'hFFFF_FFFF) begin errors++; $display("FAIL basic_imm got %h exp ffffffff", out_imm); end
    checks++; if (out_rd !== 5'd6 || out_rs1 !== 5'd5) begin errors++; $display("FAIL basic_idx got rd %0d rs1 %0d exp 6 5", out_rd, out_rs1); end
    checks++; if (out_pc !== 32'h100 || out_opcode !== 7'h13) begin errors++; $display("FAIL basic_pc_op got %h %h exp 100 13", out_pc, out_opcode); end
  endtask

  task automatic test_hazard();
    // out_valid=1 from the previous accept; the stall should drain it into a bubble
    in_valid = 1; in_instr = 32'hFFF2_8313; in_pc = 32'h104; ex_is_load = 1; ex_rd = 5'd5;
    #1;
    checks++; if (hazard_stall !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL hz_rs1 got stall %0b rdy %0b exp 1 0", hazard_stall, in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_bubble got %0b exp 0", out_valid); end
    ex_rd = 5'd6; #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hz_rd_only got %0b exp 0", hazard_stall); end
    in_instr = 32'hFE62_AE23; #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL hz_rs2_store got %0b exp 1", hazard_stall); end
    in_instr = 32'h1234_50B7; ex_rd = 5'd8; #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hz_lui got %0b exp 0", hazard_stall); end
    in_instr = 32'hFFF2_8313; ex_rd = 5'd5; ex_is_load = 0; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hz_release_rdy got %0b exp 1", in_ready); end
    tick();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h104) begin errors++; $display("FAIL hz_accept got v %0b pc %h exp 1 104", out_valid, out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hz_drain got %0b exp 0", out_valid); end
  endtask

  task automatic test_imm_back_to_back();
    logic [31:0] instr_t [10];
    logic [31:0] imm_t   [10];
    logic [2:0]  f3_t    [10];
    instr_t = '{32'hFE62AE23, 32'hFE208CE3, 32'h123450B7, 32'hFFFFF117, 32'hFFDFF06F,
                32'h402081B3, 32'hFFFFFFFF, 32'h0100A483, 32'h800100E7, 32'h000000E3};
    imm_t   = '{32'hFFFFFFFC, 32'hFFFFFFF8, 32'h12345000, 32'hFFFFF000, 32'hFFFFFFFC,
                32'h0,        32'h0,        32'h00000010, 32'hFFFFF800, 32'h00000800};
    f3_t    = '{3'd2, 3'd0, 3'd5, 3'd7, 3'd7, 3'd0, 3'd7, 3'd2, 3'd0, 3'd0};
    for (int i = 0; i < 10; i++) begin
      in_valid = 1; in_instr = instr_t[i]; in_pc = 32'h180 + 32'(i * 4);
      tick();
      checks++; if (out_valid !== 1'b1 || out_imm !== imm_t[i] || out_funct3 !== f3_t[i])
        begin errors++; $display("FAIL imm_%0d got v %0b imm %h f3 %0d exp 1 %h %0d", i, out_valid, out_imm, out_funct3, imm_t[i], f3_t[i]); end
      if (i == 5) begin
        checks++; if (out_rs1_data !== 32'h11 || out_rs2_data !== 32'h22 || out_funct7 !== 7'h20 || out_rd !== 5'd3)
          begin errors++; $display("FAIL sub_fields got %h %h f7 %h rd %0d exp 11 22 20 3", out_rs1_data, out_rs2_data, out_funct7, out_rd); end
      end
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_hold_refresh();
    in_valid = 1; in_instr = 32'h0070_8433; in_pc = 32'h200; out_ready = 1;
    tick();
    out_ready = 0; in_instr = 32'h0100_A483; in_pc = 32'h204; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_rdy got %0b exp 0", in_ready); end
    tick();
    wb_we = 1; wb_rd = 5'd7; wb_data = 32'h1234;
    tick();
    wb_rd = 5'd1; wb_data = 32'h77;
    tick();
    wb_we = 0;
    checks++; if (out_valid !== 1'b1 || out_rs2_data !== 32'h1234) begin errors++; $display("FAIL hold_rs2 got v %0b %h exp 1 00001234", out_valid, out_rs2_data); end
    checks++; if (out_rs1_data !== 32'h77) begin errors++; $display("FAIL hold_rs1 got %h exp 00000077", out_rs1_data); end
    checks++; if (out_pc !== 32'h200 || out_rd !== 5'd8 || out_rs2 !== 5'd7 || out_imm !== 32'h0)
      begin errors++; $display("FAIL hold_fields got pc %h rd %0d rs2 %0d imm %h exp 200 8 7 0", out_pc, out_rd, out_rs2, out_imm); end
    in_valid = 0; out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release got %0b exp 0", out_valid); end
  endtask

  task automatic test_flush();
    in_valid = 1; in_instr = 32'h0001_8213; in_pc = 32'h300;
    tick();
    out_ready = 0; flush = 1; in_pc = 32'h304; #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_rdy got %0b exp 0", in_ready); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", out_valid); end
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept got %0b exp 0", out_valid); end
  endtask

  task automatic test_x0_oob();
    wb_write(5'd0, 32'hDEAD);
    wb_write(5'd20, 32'hBEEF);
    in_valid = 1; in_instr = 32'h0140_0133; ex_is_load = 1; ex_rd = 5'd0; #1;
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL hz_x0 got %0b exp 0", hazard_stall); end
    tick();
    in_valid = 0; ex_is_load = 0;
    checks++; if (out_rs1_data !== 32'h0 || out_rs2_data !== 32'h0 || out_rs2 !== 5'd20)
      begin errors++; $display("FAIL x0_x20 got %h %h rs2 %0d exp 0 0 20", out_rs1_data, out_rs2_data, out_rs2); end
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] exp1;
    exp1 = BYP ? 32'h55 : 32'h33;
    wb_write(5'd3, 32'h33);
    wb_we = 1; wb_rd = 5'd3; wb_data = 32'h55;
    in_valid = 1; in_instr = 32'h0001_8213;
    tick();
    wb_we = 0;
    checks++; if (out_rs1_data !== exp1) begin errors++; $display("FAIL bypass_same got %h exp %h", out_rs1_data, exp1); end
    tick();
    in_valid = 0;
    checks++; if (out_rs1_data !== 32'h55) begin errors++; $display("FAIL bypass_next got %h exp 00000055", out_rs1_data); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hazard();
    test_imm_back_to_back();
    test_hold_refresh();
    test_flush();
    test_x0_oob();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
